// File: rtl/lcd_text_feeder.sv
// Host-to-LCD text feeder: buffers ASCII bytes and turns them into one-hot controller ops.
// Build option LCD_AUTOWRAP_EN: wrap to the other line instead of dropping bytes at the column limit.
module lcd_text_feeder #(
    parameter int NCOMMANDS   = 5,
    parameter int FIFO_DEPTH  = 16,
    parameter int COLS        = 16,
    parameter int ACK_TIMEOUT = 15,
    parameter logic [NCOMMANDS:0] OP_INIT  = (NCOMMANDS+1)'(1),
    parameter logic [NCOMMANDS:0] OP_CLEAR = (NCOMMANDS+1)'(2),
    parameter logic [NCOMMANDS:0] OP_WRITE = (NCOMMANDS+1)'(4),
    parameter logic [NCOMMANDS:0] OP_CMD   = (NCOMMANDS+1)'(8)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    char_in,
    input  logic                          char_valid,
    output logic                          char_ready,
    input  logic                          lcd_rdy,
    output logic [NCOMMANDS:0]            op_out,
    output logic [7:0]                    data_out,
    output logic                          enable_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(COLS) + 1;
    localparam int TW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] COLS_C    = CW'(COLS);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(ACK_TIMEOUT);

    localparam logic [7:0] DDRAM_LINE0 = 8'h80;
    localparam logic [7:0] DDRAM_LINE1 = 8'hC0;

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_DECODE,
        S_WRAP,
        S_ACK,
        S_DONE
    } state_t;

    // ---------------- character FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [7:0]    held_char_reg;
    logic          live_reg;
    logic          push;
    logic          pop;

    // live_reg keeps the host stalled for the whole time rst is asserted
    assign char_ready = live_reg && (count_reg < DEPTH_C);
    assign push       = char_valid && char_ready;
    assign fifo_count = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= char_in;
        end
        if (pop) begin
            held_char_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            live_reg   <= 1'b0;
        end else begin
            live_reg <= 1'b1;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ---------------- sequencing FSM ----------------
    state_t            state_reg;
    state_t            state_next;
    state_t            ret_reg;
    state_t            ret_next;
    logic [CW-1:0]     col_reg;
    logic [CW-1:0]     col_next;
    logic              line_reg;
    logic              line_next;
    logic [TW-1:0]     ack_cnt_reg;
    logic              issue;
    logic [NCOMMANDS:0] op_next;
    logic [7:0]        data_next;
    logic              printable;

    assign printable = (held_char_reg >= 8'h20) && (held_char_reg <= 8'h7E);
    assign busy      = (state_reg != S_IDLE) || (count_reg != '0);

    always_comb begin
        state_next = state_reg;
        ret_next   = ret_reg;
        col_next   = col_reg;
        line_next  = line_reg;
        op_next    = op_out;
        data_next  = data_out;
        issue      = 1'b0;
        pop        = 1'b0;

        case (state_reg)
            S_BOOT: begin
                if (lcd_rdy) begin
                    issue     = 1'b1;
                    op_next   = OP_INIT;
                    data_next = 8'h00;
                    ret_next  = S_IDLE;
                end
            end

            S_IDLE: begin
                if ((count_reg != '0) && lcd_rdy) begin
                    pop        = 1'b1;
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                state_next = S_IDLE;
                ret_next   = S_IDLE;
                if (held_char_reg == 8'h0C) begin
                    issue     = 1'b1;
                    op_next   = OP_CLEAR;
                    data_next = 8'h00;
                    col_next  = '0;
                    line_next = 1'b0;
                end else if (held_char_reg == 8'h0A) begin
                    issue     = 1'b1;
                    op_next   = OP_CMD;
                    data_next = line_reg ? DDRAM_LINE0 : DDRAM_LINE1;
                    line_next = ~line_reg;
                    col_next  = '0;
                end else if (held_char_reg == 8'h0D) begin
                    issue     = 1'b1;
                    op_next   = OP_CMD;
                    data_next = line_reg ? DDRAM_LINE1 : DDRAM_LINE0;
                    col_next  = '0;
                end else if (printable) begin
                    if (col_reg < COLS_C) begin
                        issue     = 1'b1;
                        op_next   = OP_WRITE;
                        data_next = held_char_reg;
                        col_next  = col_reg + 1'b1;
                    end
`ifdef LCD_AUTOWRAP_EN
                    else begin
                        state_next = S_WRAP;
                    end
`endif
                end
            end

            S_WRAP: begin
                // the held character is decoded again once the cursor move is acknowledged
                issue     = 1'b1;
                op_next   = OP_CMD;
                data_next = line_reg ? DDRAM_LINE0 : DDRAM_LINE1;
                line_next = ~line_reg;
                col_next  = '0;
                ret_next  = S_DECODE;
            end

            S_ACK: begin
                if (!lcd_rdy || (ack_cnt_reg == TIMEOUT_C)) begin
                    state_next = S_DONE;
                end
            end

            S_DONE: begin
                if (lcd_rdy) begin
                    state_next = ret_reg;
                end
            end

            default: begin
                state_next = S_BOOT;
            end
        endcase

        if (issue) begin
            state_next = S_ACK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_BOOT;
            ret_reg     <= S_IDLE;
            col_reg     <= '0;
            line_reg    <= 1'b0;
            ack_cnt_reg <= '0;
            op_out      <= '0;
            data_out    <= '0;
            enable_out  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ret_reg    <= ret_next;
            col_reg    <= col_next;
            line_reg   <= line_next;
            enable_out <= issue;
            if (issue) begin
                op_out   <= op_next;
                data_out <= data_next;
            end
            // saturating wait for the controller to acknowledge by dropping lcd_rdy
            if (issue) begin
                ack_cnt_reg <= '0;
            end else if ((state_reg == S_ACK) && (ack_cnt_reg != TIMEOUT_C)) begin
                ack_cnt_reg <= ack_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Directed bench for lcd_text_feeder: scoreboard of expected controller ops, checked on each enable.
module tb_lcd_text_feeder;

    localparam int COLS      = 16;
    localparam int ACK_DELAY = 3;
    localparam int LOW_LEN   = 4;
    localparam logic [5:0] OP_INIT  = 6'b000001;
    localparam logic [5:0] OP_CLEAR = 6'b000010;
    localparam logic [5:0] OP_WRITE = 6'b000100;
    localparam logic [5:0] OP_CMD   = 6'b001000;

    typedef struct packed {
        logic [5:0] op;
        logic [7:0] data;
        logic       chk_data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic       lcd_rdy;
    logic [5:0] op_out;
    logic [7:0] data_out;
    logic       enable_out;
    logic       busy;
    logic [4:0] fifo_count;

    logic manual_rdy = 1'b1;
    logic model_rdy  = 1'b1;
    logic ctrl_auto  = 1'b0;
    assign lcd_rdy = ctrl_auto ? model_rdy : manual_rdy;

    int checks = 0;
    int errors = 0;
    int issue_cnt = 0;
    int exp_total = 0;
    int m_col = 0;
    logic m_line = 1'b0;
    exp_t sb[$];

    lcd_text_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .lcd_rdy    (lcd_rdy),
        .op_out     (op_out),
        .data_out   (data_out),
        .enable_out (enable_out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [5:0] op, input logic [7:0] data, input logic chk);
        exp_t e;
        e.op = op;
        e.data = data;
        e.chk_data = chk;
        sb.push_back(e);
        exp_total++;
    endtask

    // reference model of the byte-to-op translation and cursor tracking
    task automatic expect_char(input logic [7:0] b);
        if (b == 8'h0C) begin
            sb_push(OP_CLEAR, 8'h00, 1'b0);
            m_col = 0;
            m_line = 1'b0;
        end else if (b == 8'h0A) begin
            sb_push(OP_CMD, m_line ? 8'h80 : 8'hC0, 1'b1);
            m_line = ~m_line;
            m_col = 0;
        end else if (b == 8'h0D) begin
            sb_push(OP_CMD, m_line ? 8'hC0 : 8'h80, 1'b1);
            m_col = 0;
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            if (m_col < COLS) begin
                sb_push(OP_WRITE, b, 1'b1);
                m_col++;
            end else begin
`ifdef LCD_AUTOWRAP_EN
                sb_push(OP_CMD, m_line ? 8'h80 : 8'hC0, 1'b1);
                m_line = ~m_line;
                sb_push(OP_WRITE, b, 1'b1);
                m_col = 1;
`endif
            end
        end
    endtask

    // controller model: lcd_rdy drops ACK_DELAY cycles after each enable, stays low LOW_LEN cycles
    int tmr = 0;
    always @(negedge clk) begin
        if (!ctrl_auto || rst) begin
            tmr = 0;
            model_rdy = 1'b1;
        end else if (enable_out) begin
            tmr = 1;
        end else if (tmr > 0) begin
            tmr++;
            if (tmr == ACK_DELAY + 1) model_rdy = 1'b0;
            if (tmr == ACK_DELAY + 1 + LOW_LEN) begin
                model_rdy = 1'b1;
                tmr = 0;
            end
        end
    end

    // issue monitor
    logic       prev_en = 1'b0;
    logic [5:0] last_op = 6'h00;
    logic [7:0] last_data = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            prev_en = 1'b0;
            last_op = 6'h00;
            last_data = 8'h00;
        end else begin
            if (enable_out) begin
                exp_t e;
                issue_cnt++;
                check("enable_width", 32'(prev_en), 32'd0);
                check("issue_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("op", 32'(op_out), 32'(e.op));
                    if (e.chk_data) check("data", 32'(data_out), 32'(e.data));
                    $display("issue %0d op=%b data=%02h", issue_cnt, op_out, data_out);
                end
            end else begin
                check("op_hold", 32'(op_out), 32'(last_op));
                check("data_hold", 32'(data_out), 32'(last_data));
            end
            prev_en = enable_out;
            last_op = op_out;
            last_data = data_out;
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!char_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) begin
            check("push_stall", 32'(char_ready), 32'd1);
        end else begin
            char_in = b;
            char_valid = 1'b1;
            expect_char(b);
            @(posedge clk);
            #1;
            char_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0 || !lcd_rdy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pending"}, 32'(sb.size()), 32'd0);
        check({tag, "_issues"}, 32'(issue_cnt), 32'(exp_total));
    endtask

    initial begin
        int n;
        // reset values
        repeat (3) @(negedge clk);
        check("rst_op", 32'(op_out), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_enable", 32'(enable_out), 32'd0);
        check("rst_ready", 32'(char_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);

        // boot: single INIT with lcd_rdy held high throughout
        sb_push(OP_INIT, 8'h00, 1'b0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("init_once", 32'(issue_cnt), 32'd1);
        check("init_idle_busy", 32'(busy), 32'd0);
        check("init_ready", 32'(char_ready), 32'd1);

        // "AB" with the controller model acknowledging
        ctrl_auto = 1'b1;
        push_byte(8'h41);
        push_byte(8'h42);
        wait_idle("ab");

        // newline, return, clear and a dropped control byte
        push_byte(8'h0A);
        push_byte(8'h43);
        push_byte(8'h0D);
        push_byte(8'h0A);
        push_byte(8'h01);
        push_byte(8'h44);
        push_byte(8'h0C);
        wait_idle("ctrl");

        // 17 printable bytes from column 0
        for (int i = 0; i < 17; i++) push_byte(8'h61 + 8'(i));
        wait_idle("wrap");
        push_byte(8'h0C);
        wait_idle("clear1");

        // full FIFO with lcd_rdy low: no pops, host stalls
        ctrl_auto = 1'b0;
        manual_rdy = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i));
        @(negedge clk);
        check("full_count", 32'(fifo_count), 32'd16);
        check("full_ready", 32'(char_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        char_in = 8'h5A;
        char_valid = 1'b1;
        expect_char(8'h5A);
        repeat (5) @(negedge clk);
        check("stall_count", 32'(fifo_count), 32'd16);
        check("stall_ready", 32'(char_ready), 32'd0);
        ctrl_auto = 1'b1;
        n = 0;
        while (!char_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_release", 32'(char_ready), 32'd1);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        wait_idle("full");
        push_byte(8'h0C);
        wait_idle("clear2");

        // reset while an issue awaits acknowledgement with 5 bytes still queued
        ctrl_auto = 1'b0;
        manual_rdy = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(8'h70 + 8'(i));
        @(negedge clk);
        check("preack_count", 32'(fifo_count), 32'd6);
        manual_rdy = 1'b1;
        repeat (4) @(negedge clk);
        check("ack_count", 32'(fifo_count), 32'd5);
        check("ack_pending", 32'(sb.size()), 32'd5);
        rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_enable", 32'(enable_out), 32'd0);
        check("mid_rst_op", 32'(op_out), 32'd0);
        check("mid_rst_data", 32'(data_out), 32'd0);
        check("mid_rst_ready", 32'(char_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        sb.delete();
        exp_total = issue_cnt;
        m_col = 0;
        m_line = 1'b0;
        repeat (2) @(negedge clk);
        sb_push(OP_INIT, 8'h00, 1'b0);
        rst = 1'b0;
        ctrl_auto = 1'b1;
        wait_idle("reinit");
        push_byte(8'h51);
        wait_idle("post_rst");
        check("final_count", 32'(fifo_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_text_feeder.md
Name: lcd_text_feeder

Overview:
- Upstream stage of the LCD 1602A controller. Accepts ASCII bytes from a host over a valid/ready stream and buffers them in a small FIFO.
- Translates each byte into controller operations (INIT, CLEAR, WRITE, raw CMD) and drives the controller's op, data and enable inputs, pacing itself on the controller's ready output.
- Tracks cursor column and line so that newline, form-feed and line wrap are handled without host involvement.

Parameters:
- NCOMMANDS, 5, op bus is NCOMMANDS+1 bits wide; matches the controller.
- FIFO_DEPTH, 16, character buffer entries; must be a power of 2, minimum 2.
- COLS, 16, visible columns per line.
- ACK_TIMEOUT, 15, maximum cycles to wait for lcd_rdy to fall after an issue.
- OP_INIT, 6'b000001, one-hot init op.
- OP_CLEAR, 6'b000010, one-hot clear op.
- OP_WRITE, 6'b000100, one-hot write-character op.
- OP_CMD, 6'b001000, one-hot raw-instruction op (data_out carries the instruction byte).

Ports:
- clk  in  1  system clock (20 MHz).
- rst  in  1  asynchronous reset, active-high.
- char_in  in  8  host byte.
- char_valid  in  1  host byte valid.
- char_ready  out  1  FIFO not full; a transfer occurs when char_valid && char_ready.
- lcd_rdy  in  1  controller ready.
- op_out  out  NCOMMANDS+1  one-hot op to the controller.
- data_out  out  8  character or instruction byte to the controller.
- enable_out  out  1  one-cycle issue strobe to the controller.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: op_out=0, data_out=0, enable_out=0, char_ready=0 while rst is high, busy=1, fifo_count=0. Cursor col=0, line=0. FSM enters S_BOOT.
- Reset mid-operation: FIFO contents are discarded. The INIT sequence reruns after rst is released.
- FIFO:
  - Write when char_valid && char_ready.
  - Pop only in IDLE.
  - Simultaneous push and pop leaves the count unchanged.
  - char_ready = (count < FIFO_DEPTH).
  - Pointers wrap modulo FIFO_DEPTH.
- Issue rule: op_out and data_out are registered and held stable from the enable_out cycle until the next issue. enable_out is high for exactly 1 cycle.
- FSM states:
  - S_BOOT: wait until lcd_rdy=1, then issue OP_INIT and go to S_ACK. Return target is IDLE.
  - IDLE: if the FIFO is non-empty and lcd_rdy=1, pop the head and go to DECODE the next cycle (pop-to-issue latency is 1 cycle).
  - DECODE, byte 0x0C: issue OP_CLEAR, set col=0 and line=0.
  - DECODE, byte 0x0A: issue OP_CMD with data 0xC0 if line=0 (then line=1), or 0x80 if line=1 (then line=0). Set col=0.
  - DECODE, byte 0x0D: issue OP_CMD with data 0x80 or 0xC0 for the current line. Set col=0.
  - DECODE, byte in 0x20..0x7E: issue OP_WRITE with data=byte and increment col. Column-limit handling is covered under Optional Feature.
  - DECODE, any other byte: dropped silently, no issue, return to IDLE.
  - S_ACK: wait for lcd_rdy=0. After ACK_TIMEOUT cycles without a fall, proceed anyway (covers a zero-latency controller). Then go to S_DONE.
  - S_DONE: wait for lcd_rdy=1, then go to the return target.
  - WRAP: issue OP_CMD with data 0xC0 or 0x80 (the other line), toggle line, set col=0. Go through S_ACK and S_DONE, then DECODE the held character.
- Arithmetic and widths:
  - col counts 0..COLS and is $clog2(COLS)+1 bits wide.
  - line is 1 bit.
  - The ACK timeout counter saturates at ACK_TIMEOUT.
- Boundaries:
  - Full FIFO: char_ready=0 and the host stalls; no data is lost.
  - Empty FIFO: the FSM stays in IDLE and busy=0.
  - lcd_rdy low in IDLE: no pop occurs.

Optional Feature:
- Macro: LCD_AUTOWRAP_EN.
- Defined: a printable byte arriving with col==COLS triggers WRAP first. The character is held and written at col 0 of the other line, after which col=1.
- Undefined: a printable byte with col==COLS is popped and dropped with no issue. Only 0x0A, 0x0D and 0x0C reset col.

Test Plan:
- Release rst with lcd_rdy=1 -> one enable_out pulse with op_out=6'b000001. No further issue until lcd_rdy falls and rises again.
- Push "AB" after init, with lcd_rdy dropping 3 cycles after each enable -> two OP_WRITE issues with data 0x41 then 0x42, each enable_out 1 cycle wide.
- Push 0x0A then 'C' -> OP_CMD with data 0xC0, then OP_WRITE with data 0x43. Push 0x0C -> OP_CLEAR, col=0, line=0.
- Push 17 printable bytes with LCD_AUTOWRAP_EN defined -> 16 writes, then OP_CMD 0xC0, then the 17th write. With the macro undefined -> 16 writes and the 17th byte dropped.
- Hold lcd_rdy=0 and push 16 bytes -> fifo_count=16, char_ready=0. The 17th byte stalls until lcd_rdy=1 and the first pop.
- Assert rst during S_ACK with 5 bytes queued -> outputs return to reset values and fifo_count=0 immediately. After release, OP_INIT is reissued.
